// File: rtl/hmc_mon_pkg.sv
// Shared types for the HMC AXI4-Stream protocol monitor: per-channel
// stall-watchdog state encoding and the per-channel sticky error vector.
package hmc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    TOUT  = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic valid_drop;
    logic data_change;
    logic user_change;
    logic stall_timeout;
  } ch_err_t;

endpackage

// File: rtl/hmc_axis_ch_monitor.sv
// Single-channel AXI4-Stream protocol checker: captures a stalled beat,
// flags TVALID drops and TDATA/TUSER changes on the following cycle, counts
// handshakes and violation cycles. The stall watchdog FSM is compiled in
// only when HMC_MON_STALL_WATCHDOG_EN is defined.
module hmc_axis_ch_monitor
  import hmc_mon_pkg::*;
#(
  parameter int DWIDTH            = 512,
  parameter int NUM_DATA_BYTES    = 64,
  parameter int CNT_WIDTH         = 16,
  parameter int STALL_TIMEOUT_LOG = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_tvalid,
  input  logic                      i_tready,
  input  logic [DWIDTH-1:0]         i_tdata,
  input  logic [NUM_DATA_BYTES-1:0] i_tuser,
  input  logic                      i_clr,
  output ch_err_t                   o_err,
  output logic [CNT_WIDTH-1:0]      o_beat_cnt,
  output logic [CNT_WIDTH-1:0]      o_viol_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                      r_pending;
  logic [DWIDTH-1:0]         r_data;
  logic [NUM_DATA_BYTES-1:0] r_user;
  ch_err_t                   r_err;
  logic [CNT_WIDTH-1:0]      r_beat_cnt;
  logic [CNT_WIDTH-1:0]      r_viol_cnt;

  logic w_stalled;
  logic w_drop;
  logic w_dchg;
  logic w_uchg;
  logic w_viol_any;
  logic w_tout_set;

  assign w_stalled = i_tvalid & ~i_tready;

  // A beat offered but not accepted must be re-offered unchanged next cycle.
  // Data/user comparisons are only meaningful while TVALID is still high.
  assign w_drop     = r_pending & ~i_tvalid;
  assign w_dchg     = r_pending & i_tvalid & (i_tdata != r_data);
  assign w_uchg     = r_pending & i_tvalid & (i_tuser != r_user);
  assign w_viol_any = w_drop | w_dchg | w_uchg;

  // Capture the stalled beat and remember that a check is due next cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_data    <= '0;
      r_user    <= '0;
    end else begin
      r_pending <= w_stalled;
      if (w_stalled) begin
        r_data <= i_tdata;
        r_user <= i_tuser;
      end
    end
  end

`ifdef HMC_MON_STALL_WATCHDOG_EN
  // The count includes the edge that entered STALL, so while in STALL it
  // equals the number of consecutive stalled cycles seen so far.
  localparam logic [STALL_TIMEOUT_LOG-1:0] STALL_LAST =
    STALL_TIMEOUT_LOG'((2 ** STALL_TIMEOUT_LOG) - 2);

  mon_state_e                   r_state;
  mon_state_e                   w_state_nxt;
  logic [STALL_TIMEOUT_LOG-1:0] r_stall_cnt;
  logic                         r_tout_entry;

  // Watchdog state register and one-shot marker for TOUT entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_tout_entry <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tout_entry <= (w_state_nxt == TOUT) && (r_state != TOUT);
    end
  end

  // Watchdog next-state: leave on acceptance or withdrawal, time out at the limit
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_stalled) w_state_nxt = STALL;
      STALL: begin
        if (!w_stalled)                       w_state_nxt = IDLE;
        else if (r_stall_cnt >= STALL_LAST)   w_state_nxt = TOUT;
      end
      TOUT:    if (!w_stalled) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Saturating stall-length counter, cleared whenever the stall ends or times out
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stalled && (r_state != TOUT)) begin
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign w_tout_set = r_tout_entry;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (STALL_TIMEOUT_LOG > 0);
  assign w_tout_set   = 1'b0;
`endif

  // Sticky flags: a new detection wins over a coincident clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= '0;
    end else begin
      r_err.valid_drop    <= (r_err.valid_drop    & ~i_clr) | w_drop;
      r_err.data_change   <= (r_err.data_change   & ~i_clr) | w_dchg;
      r_err.user_change   <= (r_err.user_change   & ~i_clr) | w_uchg;
      r_err.stall_timeout <= (r_err.stall_timeout & ~i_clr) | w_tout_set;
    end
  end

  // Handshake counter, wraps naturally; unaffected by the error clear
  always_ff @(posedge i_clk) begin
    if (i_rst)                    r_beat_cnt <= '0;
    else if (i_tvalid & i_tready) r_beat_cnt <= r_beat_cnt + 1'b1;
  end

  // Violation-cycle counter, saturating; a clear with a new violation restarts at 1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_viol_cnt <= '0;
    end else if (i_clr) begin
      r_viol_cnt <= w_viol_any ? CNT_WIDTH'(1) : '0;
    end else if (w_viol_any && (r_viol_cnt != CNT_MAX)) begin
      r_viol_cnt <= r_viol_cnt + 1'b1;
    end
  end

  assign o_err      = r_err;
  assign o_beat_cnt = r_beat_cnt;
  assign o_viol_cnt = r_viol_cnt;

endmodule

// File: rtl/hmc_axis_protocol_monitor.sv
// Top level of the HMC AXI4-Stream protocol monitor: one checker per channel,
// register-file read/write conflict detection, error-clear fan-out and irq.
// Optional stall watchdog enabled by defining HMC_MON_STALL_WATCHDOG_EN.
// NUM_CH is expected to be in 1..8.
module hmc_axis_protocol_monitor
  import hmc_mon_pkg::*;
#(
  parameter int NUM_CH            = 2,
  parameter int DWIDTH            = 512,
  parameter int NUM_DATA_BYTES    = 64,
  parameter int CNT_WIDTH         = 16,
  parameter int STALL_TIMEOUT_LOG = 10
) (
  input  logic                             clk_hmc,
  input  logic                             res_hmc,
  input  logic [NUM_CH-1:0]                axis_tvalid,
  input  logic [NUM_CH-1:0]                axis_tready,
  input  logic [NUM_CH*DWIDTH-1:0]         axis_tdata,
  input  logic [NUM_CH*NUM_DATA_BYTES-1:0] axis_tuser,
  input  logic                             rf_read_en,
  input  logic                             rf_write_en,
  input  logic                             clr_errors,
  output logic [NUM_CH-1:0]                err_valid_drop,
  output logic [NUM_CH-1:0]                err_data_change,
  output logic [NUM_CH-1:0]                err_user_change,
  output logic [NUM_CH-1:0]                err_stall_timeout,
  output logic                             err_rf_conflict,
  output logic [NUM_CH*CNT_WIDTH-1:0]      beat_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]      viol_cnt,
  output logic                             irq
);

  ch_err_t w_err [NUM_CH];
  logic    r_rf_conflict;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    hmc_axis_ch_monitor #(
      .DWIDTH            (DWIDTH),
      .NUM_DATA_BYTES    (NUM_DATA_BYTES),
      .CNT_WIDTH         (CNT_WIDTH),
      .STALL_TIMEOUT_LOG (STALL_TIMEOUT_LOG)
    ) u_ch (
      .i_clk      (clk_hmc),
      .i_rst      (res_hmc),
      .i_tvalid   (axis_tvalid[gi]),
      .i_tready   (axis_tready[gi]),
      .i_tdata    (axis_tdata[gi*DWIDTH +: DWIDTH]),
      .i_tuser    (axis_tuser[gi*NUM_DATA_BYTES +: NUM_DATA_BYTES]),
      .i_clr      (clr_errors),
      .o_err      (w_err[gi]),
      .o_beat_cnt (beat_cnt[gi*CNT_WIDTH +: CNT_WIDTH]),
      .o_viol_cnt (viol_cnt[gi*CNT_WIDTH +: CNT_WIDTH])
    );

    assign err_valid_drop[gi]    = w_err[gi].valid_drop;
    assign err_data_change[gi]   = w_err[gi].data_change;
    assign err_user_change[gi]   = w_err[gi].user_change;
    assign err_stall_timeout[gi] = w_err[gi].stall_timeout;
  end

  // Sticky RF conflict flag: simultaneous read and write strobes
  always_ff @(posedge clk_hmc) begin
    if (res_hmc) r_rf_conflict <= 1'b0;
    else         r_rf_conflict <= (r_rf_conflict & ~clr_errors) | (rf_read_en & rf_write_en);
  end

  assign err_rf_conflict = r_rf_conflict;

  // Interrupt is a pure OR of the flag registers, no added latency
  always_comb begin
    irq = r_rf_conflict | (|err_valid_drop) | (|err_data_change) |
          (|err_user_change) | (|err_stall_timeout);
  end

endmodule

// File: tb/tb_hmc_axis_protocol_monitor.sv
// Directed self-checking bench for hmc_axis_protocol_monitor with a small
// NUM_CH=2 / 8-bit data / 4-bit counters / STALL_TIMEOUT_LOG=4 configuration.
module tb_hmc_axis_protocol_monitor;

  localparam int NUM_CH = 2;
  localparam int DW     = 8;
  localparam int UW     = 4;
  localparam int CW     = 4;
  localparam int STL    = 4;

  localparam int SIG_VD   = 0;
  localparam int SIG_DC   = 1;
  localparam int SIG_UC   = 2;
  localparam int SIG_TO   = 3;
  localparam int SIG_RF   = 4;
  localparam int SIG_BEAT = 5;
  localparam int SIG_VIOL = 6;
  localparam int SIG_IRQ  = 7;

  logic                   clk_hmc = 1'b0;
  logic                   res_hmc;
  logic [NUM_CH-1:0]      axis_tvalid;
  logic [NUM_CH-1:0]      axis_tready;
  logic [NUM_CH*DW-1:0]   axis_tdata;
  logic [NUM_CH*UW-1:0]   axis_tuser;
  logic                   rf_read_en;
  logic                   rf_write_en;
  logic                   clr_errors;
  logic [NUM_CH-1:0]      err_valid_drop;
  logic [NUM_CH-1:0]      err_data_change;
  logic [NUM_CH-1:0]      err_user_change;
  logic [NUM_CH-1:0]      err_stall_timeout;
  logic                   err_rf_conflict;
  logic [NUM_CH*CW-1:0]   beat_cnt;
  logic [NUM_CH*CW-1:0]   viol_cnt;
  logic                   irq;

  hmc_axis_protocol_monitor #(
    .NUM_CH            (NUM_CH),
    .DWIDTH            (DW),
    .NUM_DATA_BYTES    (UW),
    .CNT_WIDTH         (CW),
    .STALL_TIMEOUT_LOG (STL)
  ) dut (
    .clk_hmc           (clk_hmc),
    .res_hmc           (res_hmc),
    .axis_tvalid       (axis_tvalid),
    .axis_tready       (axis_tready),
    .axis_tdata        (axis_tdata),
    .axis_tuser        (axis_tuser),
    .rf_read_en        (rf_read_en),
    .rf_write_en       (rf_write_en),
    .clr_errors        (clr_errors),
    .err_valid_drop    (err_valid_drop),
    .err_data_change   (err_data_change),
    .err_user_change   (err_user_change),
    .err_stall_timeout (err_stall_timeout),
    .err_rf_conflict   (err_rf_conflict),
    .beat_cnt          (beat_cnt),
    .viol_cnt          (viol_cnt),
    .irq               (irq)
  );

  always #5 clk_hmc = ~clk_hmc;

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic wd_on;

  function automatic logic [31:0] get_obs(input int sig);
    case (sig)
      SIG_VD:   return 32'(err_valid_drop);
      SIG_DC:   return 32'(err_data_change);
      SIG_UC:   return 32'(err_user_change);
      SIG_TO:   return 32'(err_stall_timeout);
      SIG_RF:   return 32'(err_rf_conflict);
      SIG_BEAT: return 32'(beat_cnt);
      SIG_VIOL: return 32'(viol_cnt);
      SIG_IRQ:  return 32'(irq);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input int sig, input logic [31:0] val, input string tag);
    exp_t e;
    e.sig = sig;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = get_obs(e.sig);
      n_checks++;
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_hmc);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic r,
                        input logic [DW-1:0] d, input logic [UW-1:0] u);
    axis_tvalid[ch]         = v;
    axis_tready[ch]         = r;
    axis_tdata[ch*DW +: DW] = d;
    axis_tuser[ch*UW +: UW] = u;
  endtask

  task automatic pulse_clr();
    clr_errors = 1'b1;
    tick();
    clr_errors = 1'b0;
  endtask

  task automatic do_reset();
    res_hmc = 1'b1;
    tick();
    tick();
    res_hmc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
`ifdef HMC_MON_STALL_WATCHDOG_EN
    wd_on = 1'b1;
`else
    wd_on = 1'b0;
`endif
    axis_tvalid = '0;
    axis_tready = '0;
    axis_tdata  = '0;
    axis_tuser  = '0;
    rf_read_en  = 1'b0;
    rf_write_en = 1'b0;
    clr_errors  = 1'b0;
    do_reset();

    // Reset state
    push(SIG_VD, 0, "rst_vd");   push(SIG_DC, 0, "rst_dc");
    push(SIG_UC, 0, "rst_uc");   push(SIG_TO, 0, "rst_to");
    push(SIG_RF, 0, "rst_rf");   push(SIG_BEAT, 0, "rst_beat");
    push(SIG_VIOL, 0, "rst_viol"); push(SIG_IRQ, 0, "rst_irq");
    drain();

    // Data change on ch0: A5 stalled, then 5A (accepted)
    set_ch(0, 1, 0, 8'hA5, 4'h1);
    tick();
    set_ch(0, 1, 1, 8'h5A, 4'h1);
    tick();
    set_ch(0, 0, 0, 8'h5A, 4'h1);
    push(SIG_DC, 32'h1, "dc_ch0");   push(SIG_VD, 0, "dc_vd");
    push(SIG_UC, 0, "dc_uc");        push(SIG_VIOL, 32'h01, "dc_viol");
    push(SIG_BEAT, 32'h01, "dc_beat"); push(SIG_IRQ, 1, "dc_irq");
    drain();
    pulse_clr();
    push(SIG_DC, 0, "clr_dc"); push(SIG_VIOL, 0, "clr_viol");
    push(SIG_IRQ, 0, "clr_irq"); push(SIG_BEAT, 32'h01, "clr_beat");
    drain();

    // Valid drop on ch1
    set_ch(1, 1, 0, 8'h33, 4'h0);
    tick();
    set_ch(1, 0, 0, 8'h33, 4'h0);
    tick();
    push(SIG_VD, 32'h2, "vd_ch1"); push(SIG_DC, 0, "vd_dc");
    push(SIG_VIOL, 32'h10, "vd_viol"); push(SIG_IRQ, 1, "vd_irq");
    drain();
    pulse_clr();

    // User change on ch1 (accepted on the changed cycle)
    set_ch(1, 1, 0, 8'h33, 4'h5);
    tick();
    set_ch(1, 1, 1, 8'h33, 4'h6);
    tick();
    set_ch(1, 0, 0, 8'h33, 4'h6);
    push(SIG_UC, 32'h2, "uc_ch1"); push(SIG_DC, 0, "uc_dc");
    push(SIG_VIOL, 32'h10, "uc_viol"); push(SIG_BEAT, 32'h11, "uc_beat");
    drain();
    pulse_clr();

    // Simultaneous violations on both channels
    set_ch(0, 1, 0, 8'h10, 4'h0);
    set_ch(1, 1, 0, 8'h20, 4'h0);
    tick();
    set_ch(0, 1, 1, 8'h11, 4'h0);
    set_ch(1, 0, 0, 8'h20, 4'h0);
    tick();
    set_ch(0, 0, 0, 8'h11, 4'h0);
    push(SIG_DC, 32'h1, "sim_dc"); push(SIG_VD, 32'h2, "sim_vd");
    push(SIG_VIOL, 32'h11, "sim_viol"); push(SIG_BEAT, 32'h12, "sim_beat");
    drain();
    pulse_clr();
    push(SIG_VD, 0, "sim_clr_vd"); push(SIG_IRQ, 0, "sim_clr_irq");
    drain();

    // RF read/write conflict, sticky until cleared; beat count untouched
    rf_read_en  = 1'b1;
    rf_write_en = 1'b1;
    tick();
    rf_read_en  = 1'b0;
    rf_write_en = 1'b0;
    push(SIG_RF, 1, "rf_set"); push(SIG_IRQ, 1, "rf_irq");
    drain();
    tick();
    push(SIG_RF, 1, "rf_sticky");
    drain();
    pulse_clr();
    push(SIG_RF, 0, "rf_clr"); push(SIG_IRQ, 0, "rf_clr_irq");
    push(SIG_BEAT, 32'h12, "rf_clr_beat");
    drain();

    // Clear coincident with a new detection: flag stays, viol_cnt restarts at 1
    set_ch(0, 1, 0, 8'h11, 4'h0);
    tick();
    set_ch(0, 1, 0, 8'h22, 4'h0);
    tick();
    push(SIG_VIOL, 32'h01, "co_viol1");
    drain();
    set_ch(0, 1, 0, 8'h33, 4'h0);
    tick();
    push(SIG_VIOL, 32'h02, "co_viol2");
    drain();
    set_ch(0, 1, 1, 8'h44, 4'h0);
    clr_errors = 1'b1;
    tick();
    clr_errors = 1'b0;
    set_ch(0, 0, 0, 8'h44, 4'h0);
    push(SIG_DC, 32'h1, "co_dc"); push(SIG_VIOL, 32'h01, "co_viol");
    push(SIG_IRQ, 1, "co_irq"); push(SIG_BEAT, 32'h13, "co_beat");
    drain();
    pulse_clr();

    // Reset in the middle of a stall discards the pending check
    set_ch(1, 1, 0, 8'h07, 4'h0);
    tick();
    res_hmc = 1'b1;
    set_ch(1, 0, 0, 8'h08, 4'h0);
    tick();
    res_hmc = 1'b0;
    tick();
    push(SIG_VD, 0, "rs_vd"); push(SIG_DC, 0, "rs_dc");
    push(SIG_VIOL, 0, "rs_viol"); push(SIG_BEAT, 0, "rs_beat");
    push(SIG_IRQ, 0, "rs_irq");
    drain();

    // 17 handshakes on ch0 with 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) begin
      set_ch(0, 1, 1, 8'(i), 4'h0);
      tick();
    end
    set_ch(0, 0, 0, 8'h00, 4'h0);
    push(SIG_BEAT, 32'h01, "wrap_beat"); push(SIG_VIOL, 0, "wrap_viol");
    drain();

    // 20 consecutive data-change cycles saturate viol_cnt at 15
    set_ch(0, 1, 0, 8'h00, 4'h0);
    tick();
    for (int i = 1; i <= 20; i++) begin
      set_ch(0, 1, 0, 8'(i), 4'h0);
      tick();
      if (i == 14) begin
        push(SIG_VIOL, 32'h0E, "sat_viol14");
        drain();
      end
    end
    set_ch(0, 1, 1, 8'd20, 4'h0);
    tick();
    set_ch(0, 0, 0, 8'd20, 4'h0);
    push(SIG_VIOL, 32'h0F, "sat_viol"); push(SIG_DC, 32'h1, "sat_dc");
    push(SIG_BEAT, 32'h02, "sat_beat");
    drain();
    do_reset();

    // Stall watchdog: ch0 held stalled for 20 cycles, constant data
    set_ch(0, 1, 0, 8'h55, 4'h3);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) begin
        push(SIG_TO, 0, "to_k15");
        drain();
      end
      if (k == 16) begin
        push(SIG_TO, {31'd0, wd_on}, "to_k16");
        push(SIG_IRQ, {31'd0, wd_on}, "to_irq16");
        drain();
      end
      if (k == 20) begin
        push(SIG_TO, {31'd0, wd_on}, "to_k20");
        push(SIG_VIOL, 0, "to_viol");
        drain();
      end
    end
    set_ch(0, 1, 1, 8'h55, 4'h3);
    tick();
    set_ch(0, 0, 0, 8'h55, 4'h3);
    tick();
    pulse_clr();
    push(SIG_TO, 0, "to_clr"); push(SIG_IRQ, 0, "to_clr_irq");
    push(SIG_BEAT, 32'h01, "to_beat");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hmc_axis_protocol_monitor.md
HMC_AXIS_PROTOCOL_MONITOR -- requirements
Module: hmc_axis_protocol_monitor

Interface
REQ-001 Parameter NUM_CH, default 2: number of monitored AXI4-Stream channels, legal 1..8.
REQ-002 Parameter DWIDTH, default 512: TDATA width per channel.
REQ-003 Parameter NUM_DATA_BYTES, default 64: TUSER width per channel.
REQ-004 Parameter CNT_WIDTH, default 16: width of the beat and violation counters.
REQ-005 Parameter STALL_TIMEOUT_LOG, default 10: stall limit is 2^STALL_TIMEOUT_LOG-1 cycles.
REQ-006 One clock and one reset; reset is synchronous and active-high.
REQ-007 Port clk_hmc, in, 1: sole clock; all logic is on the rising edge.
REQ-008 Port res_hmc, in, 1: synchronous reset, active-high.
REQ-009 Port axis_tvalid, in, NUM_CH: TVALID per channel.
REQ-010 Port axis_tready, in, NUM_CH: TREADY per channel.
REQ-011 Port axis_tdata, in, NUM_CH*DWIDTH: TDATA per channel; channel i occupies bits [i*DWIDTH +: DWIDTH].
REQ-012 Port axis_tuser, in, NUM_CH*NUM_DATA_BYTES: TUSER per channel, packed the same way as axis_tdata.
REQ-013 Ports rf_read_en and rf_write_en, in, 1 each: register-file access strobes.
REQ-014 Port clr_errors, in, 1: clears all sticky flags and violation counters.
REQ-015 Ports err_valid_drop, err_data_change, err_user_change and err_stall_timeout, out, NUM_CH each: sticky per-channel error flags.
REQ-016 Port err_rf_conflict, out, 1: sticky flag for a simultaneous RF read and write.
REQ-017 Port beat_cnt, out, NUM_CH*CNT_WIDTH: handshake count per channel.
REQ-018 Port viol_cnt, out, NUM_CH*CNT_WIDTH: violation count per channel.
REQ-019 Port irq, out, 1: OR of all sticky flags.

Function
REQ-020 A channel is pending when, at edge N, tvalid=1 and tready=0; at that edge the monitor SHALL capture tdata and tuser.
REQ-021 In cycle N+1 of a pending channel, the monitor SHALL flag tvalid=0 as a valid drop, tdata different from the captured value as a data change, and tuser different from the captured value as a user change.
REQ-022 The corresponding flag SHALL be high from cycle N+2 and stay high until cleared.
REQ-023 Each channel SHALL run a three-state FSM: IDLE goes to STALL on valid&!ready; STALL goes to IDLE on ready or !valid; STALL goes to TOUT when the stall counter reaches 2^STALL_TIMEOUT_LOG-1; TOUT goes to IDLE on ready or !valid.
REQ-024 The stall counter SHALL increment in STALL, reset to 0 otherwise, and saturate (never wrap).
REQ-025 Entry into TOUT SHALL set err_stall_timeout[i] one cycle later.
REQ-026 beat_cnt[i] SHALL increment on each valid&ready and wrap modulo 2^CNT_WIDTH.
REQ-027 viol_cnt[i] SHALL increment by 1 per cycle in which any violation is detected on channel i, regardless of how many, and saturate at all-ones.
REQ-028 rf_read_en&rf_write_en in the same cycle SHALL set err_rf_conflict on the next cycle.
REQ-029 clr_errors SHALL zero all sticky flags and viol_cnt on the next edge; if a violation is detected in the same cycle as clr_errors, setting wins and viol_cnt loads 1.
REQ-030 clr_errors SHALL NOT affect beat_cnt or the FSMs.
REQ-031 irq SHALL be a combinational OR of the flag registers, with no additional latency.
REQ-032 Channels SHALL be fully independent; simultaneous violations on several channels are each recorded.

Reset
REQ-033 While res_hmc=1 at an edge, all flags, counters, capture registers and pending bits SHALL go to 0, all FSMs to IDLE, and irq to 0.
REQ-034 Reset asserted mid-stall SHALL discard the pending check; no flag is set for the cycle after reset deassertion.

Configuration
REQ-035 Macro HMC_MON_STALL_WATCHDOG_EN defined: the FSM, stall counter and err_stall_timeout logic SHALL be compiled in.
REQ-036 Macro HMC_MON_STALL_WATCHDOG_EN undefined: err_stall_timeout SHALL be tied to 0, with no stall counter or FSM state.

Structure
REQ-037 Package hmc_mon_pkg SHALL hold the FSM state enum (IDLE, STALL, TOUT) and an error-vector struct typedef.
REQ-038 Per-channel logic SHALL live in sub-module hmc_axis_ch_monitor, instantiated NUM_CH times by a generate loop.
REQ-039 The top level SHALL hold only the RF check, clear distribution and irq.

Verification
REQ-040 Ch0 valid=1 ready=0 with tdata=0xA5 at cycle 5, tdata=0x5A at cycle 6 -> err_data_change[0]=1 from cycle 7, viol_cnt[0]=1, irq=1, other channels 0.
REQ-041 Ch1 valid=1 ready=0 at cycle 3, valid=0 at cycle 4 -> err_valid_drop[1]=1 at cycle 5.
REQ-042 STALL_TIMEOUT_LOG=4, ch0 held valid=1 ready=0 for 20 cycles -> err_stall_timeout[0] rises exactly 16 cycles after stall start; undefined macro -> stays 0.
REQ-043 rf_read_en=rf_write_en=1 for one cycle -> err_rf_conflict=1 next cycle; clr_errors pulse -> 0, while beat_cnt is unchanged.
REQ-044 CNT_WIDTH=4, 17 handshakes on ch0 -> beat_cnt[0]=1; 20 violation cycles -> viol_cnt[0]=15.
REQ-045 clr_errors coincident with a new data-change detection -> flag remains 1 and viol_cnt=1.
